// File: rtl/ddc_pkg.sv
// -----------------------------------------------------------------------------
// ddc_pkg
// Shared definitions for the DDC output framing stage.
//   framer_state_t : packet framer state (no packet open / packet open)
//   DDC_SAMPLE_W   : native sc16 sample width (I in [31:16], Q in [15:0])
// -----------------------------------------------------------------------------
package ddc_pkg;

    localparam int DDC_SAMPLE_W = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } framer_state_t;

endpackage : ddc_pkg

// File: rtl/ddc_out_reg.sv
// -----------------------------------------------------------------------------
// ddc_out_reg
// Single-entry output register for the framer: holds {tdata, tlast, teob, tlen}
// behind a valid/ready handshake. A synchronous clear empties the entry.
//
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   clear_i           : synchronous flush, drops the held beat
//   in_valid_i        : load request (already qualified by the caller)
//   in_data_i/last/eob/len_i : beat to load
//   in_ready_o        : entry can take a beat this cycle
//   out_valid_o       : entry holds a beat
//   out_data/last/eob/len_o : held beat, stable while out_valid_o && !out_ready_i
//   out_ready_i       : downstream takes the held beat
// -----------------------------------------------------------------------------
module ddc_out_reg #(
    parameter int DATA_W = 32,
    parameter int SPP_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_last_i,
    input  logic              in_eob_i,
    input  logic [SPP_W-1:0]  in_len_i,
    output logic              in_ready_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_last_o,
    output logic              out_eob_o,
    output logic [SPP_W-1:0]  out_len_o,
    input  logic              out_ready_i
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic              last_q;
    logic              eob_q;
    logic [SPP_W-1:0]  len_q;
    logic              load;

    // The entry frees up in the same cycle the downstream takes it, so a
    // continuously ready sink sees one beat per cycle.
    assign in_ready_o = !valid_q || out_ready_i;
    assign load       = in_valid_i && in_ready_o;

    // NOTE: the payload register is reset as well as the valid bit, because
    // the outputs must read as zero out of reset, not just be marked invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples its inputs from before the clock edge.
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            eob_q   <= 1'b0;
            len_q   <= '0;
        end else if (clear_i) begin
            // Clear wins over any pending handshake: the held beat is dropped.
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            eob_q   <= 1'b0;
            len_q   <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= in_data_i;
            last_q  <= in_last_i;
            eob_q   <= in_eob_i;
            len_q   <= in_len_i;
        end else if (out_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_last_o  = last_q;
    assign out_eob_o   = eob_q;
    assign out_len_o   = len_q;

endmodule : ddc_out_reg

// File: rtl/ddc_out_framer.sv
// -----------------------------------------------------------------------------
// ddc_out_framer
// Cuts the decimated sc16 stream into packets of cfg_spp samples, closing a
// packet early on end-of-burst. Emits tlast, teob and the packet sample count
// (tlen) for the CHDR packetizer. One output register stage, 1-cycle latency.
//
// Ports
//   ddc_clk, ddc_rst_n : clock, asynchronous active-low reset
//   clear              : synchronous flush of the open packet and output beat
//   cfg_spp            : samples per packet (0 treated as 1), sampled at open
//   s_axis_*           : input sample stream (tdata, teob, tvalid, tready)
//   m_axis_*           : framed output (tdata, tlast, teob, tlen, tvalid, tready)
//                        teob/tlen are zero on non-last beats
//   stat_pkt_cnt       : packets completed        (only with DDC_FRAMER_STATS_EN)
//   stat_eob_cnt       : EOB packets completed    (only with DDC_FRAMER_STATS_EN)
//
// Optional feature macro: DDC_FRAMER_STATS_EN
// -----------------------------------------------------------------------------
module ddc_out_framer
    import ddc_pkg::*;
#(
    parameter int SPP_W  = 16,
    parameter int DATA_W = DDC_SAMPLE_W
) (
    input  logic              ddc_clk,
    input  logic              ddc_rst_n,
    input  logic              clear,
    input  logic [SPP_W-1:0]  cfg_spp,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_teob,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tlast,
    output logic              m_axis_teob,
    output logic [SPP_W-1:0]  m_axis_tlen,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready
`ifdef DDC_FRAMER_STATS_EN
    ,
    output logic [31:0]       stat_pkt_cnt,
    output logic [31:0]       stat_eob_cnt
`endif
);

    localparam logic [SPP_W-1:0] ONE = SPP_W'(1);

    framer_state_t    state_q, state_d;
    logic [SPP_W-1:0] cnt_q, cnt_d;
    logic [SPP_W-1:0] spp_q, spp_d;

    logic             reg_ready;
    logic             accept;
    logic [SPP_W-1:0] eff_spp;
    logic [SPP_W-1:0] cnt_inc;
    logic             pkt_end;
    logic [SPP_W-1:0] pkt_len;

    assign s_axis_tready = !clear && reg_ready;
    assign accept        = s_axis_tvalid && s_axis_tready;

    // A zero SPP would never hit the boundary; treat it as single-sample.
    assign eff_spp = (cfg_spp == '0) ? ONE : cfg_spp;
    assign cnt_inc = cnt_q + ONE;

    // NOTE: every signal driven here gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        spp_d   = spp_q;
        pkt_end = 1'b0;
        pkt_len = '0;

        if (clear) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (accept) begin
            unique case (state_q)
                ST_IDLE: begin
                    spp_d = eff_spp;
                    if (eff_spp == ONE || s_axis_teob) begin
                        // Single-sample packet: opens and closes on this beat.
                        pkt_end = 1'b1;
                        pkt_len = ONE;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_PKT;
                        cnt_d   = ONE;
                    end
                end
                ST_PKT: begin
                    // cnt_inc counts the current sample as part of the packet.
                    if (cnt_inc == spp_q || s_axis_teob) begin
                        pkt_end = 1'b1;
                        pkt_len = cnt_inc;
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_inc;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge ddc_clk or negedge ddc_rst_n) begin
        if (!ddc_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            spp_q   <= ONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            spp_q   <= spp_d;
        end
    end

    ddc_out_reg #(
        .DATA_W (DATA_W),
        .SPP_W  (SPP_W)
    ) u_out_reg (
        .clk         (ddc_clk),
        .rst_n       (ddc_rst_n),
        .clear_i     (clear),
        .in_valid_i  (accept),
        .in_data_i   (s_axis_tdata),
        .in_last_i   (pkt_end),
        .in_eob_i    (pkt_end && s_axis_teob),
        .in_len_i    (pkt_len),
        .in_ready_o  (reg_ready),
        .out_valid_o (m_axis_tvalid),
        .out_data_o  (m_axis_tdata),
        .out_last_o  (m_axis_tlast),
        .out_eob_o   (m_axis_teob),
        .out_len_o   (m_axis_tlen),
        .out_ready_i (m_axis_tready)
    );

`ifdef DDC_FRAMER_STATS_EN
    logic [31:0] pkt_cnt_q;
    logic [31:0] eob_cnt_q;
    logic        last_hs;

    // A beat dropped by clear never completes its handshake.
    assign last_hs = m_axis_tvalid && m_axis_tready && !clear && m_axis_tlast;

    always_ff @(posedge ddc_clk or negedge ddc_rst_n) begin
        if (!ddc_rst_n) begin
            pkt_cnt_q <= '0;
            eob_cnt_q <= '0;
        end else if (last_hs) begin
            pkt_cnt_q <= pkt_cnt_q + 32'd1;
            if (m_axis_teob) begin
                eob_cnt_q <= eob_cnt_q + 32'd1;
            end
        end
    end

    assign stat_pkt_cnt = pkt_cnt_q;
    assign stat_eob_cnt = eob_cnt_q;
`endif

endmodule : ddc_out_framer

// File: tb/tb_ddc_out_framer.sv
// -----------------------------------------------------------------------------
// tb_ddc_out_framer
// Directed self-checking bench for ddc_out_framer. Inputs change 1 time unit
// after the rising edge; handshakes are observed on the falling edge.
// Build with +define+DDC_FRAMER_STATS_EN to include the statistics checks.
// -----------------------------------------------------------------------------
module tb_ddc_out_framer;

    localparam int SPP_W  = 16;
    localparam int DATA_W = 32;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
        logic              eob;
        logic [SPP_W-1:0]  len;
        int                cyc;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clear;
    logic [SPP_W-1:0]  cfg_spp;
    logic [DATA_W-1:0] s_tdata;
    logic              s_teob;
    logic              s_tvalid;
    logic              s_tready;
    logic [DATA_W-1:0] m_tdata;
    logic              m_tlast;
    logic              m_teob;
    logic [SPP_W-1:0]  m_tlen;
    logic              m_tvalid;
    logic              m_tready;
`ifdef DDC_FRAMER_STATS_EN
    logic [31:0]       stat_pkt_cnt;
    logic [31:0]       stat_eob_cnt;
`endif

    int    errors = 0;
    int    checks = 0;
    int    cyc    = 0;
    bit    stall_en = 1'b0;
    beat_t beat_q[$];
    beat_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ddc_out_framer #(
        .SPP_W  (SPP_W),
        .DATA_W (DATA_W)
    ) dut (
        .ddc_clk       (clk),
        .ddc_rst_n     (rst_n),
        .clear         (clear),
        .cfg_spp       (cfg_spp),
        .s_axis_tdata  (s_tdata),
        .s_axis_teob   (s_teob),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tlast  (m_tlast),
        .m_axis_teob   (m_teob),
        .m_axis_tlen   (m_tlen),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready)
`ifdef DDC_FRAMER_STATS_EN
        ,
        .stat_pkt_cnt  (stat_pkt_cnt),
        .stat_eob_cnt  (stat_eob_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: records every completed handshake (clear drops the beat).
    always @(negedge clk) begin
        if (rst_n && m_tvalid && m_tready && !clear) begin
            beat_q.push_back('{data: m_tdata, last: m_tlast, eob: m_teob, len: m_tlen, cyc: cyc});
        end
    end

    // Stability monitor: a stalled beat must not change until it is taken.
    logic              hold_vld = 1'b0;
    logic [DATA_W+SPP_W+1:0] hold_beat;
    always @(negedge clk) begin
        if (hold_vld && rst_n && m_tvalid && !clear) begin
            check("stall_stable", {m_tdata, m_tlast, m_teob, m_tlen}, hold_beat);
        end
        hold_vld  = rst_n && m_tvalid && !m_tready && !clear;
        hold_beat = {m_tdata, m_tlast, m_teob, m_tlen};
    end

    // Random downstream stall, ~25% of cycles.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (stall_en) m_tready = ($urandom_range(0, 3) != 0);
        end
    end

    // Watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one sample and hold it until accepted (bounded wait).
    task automatic send(input logic [DATA_W-1:0] d, input logic eob);
        bit done;
        int n;
        done     = 1'b0;
        n        = 0;
        s_tdata  = d;
        s_teob   = eob;
        s_tvalid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (s_tready) begin
                done = 1'b1;
            end else if (++n > 200) begin
                check("send_timeout", 64'(n), 64'd0);
                done = 1'b1;
            end
            step();
        end
    endtask

    task automatic drain();
        int n;
        n        = 0;
        s_tvalid = 1'b0;
        s_teob   = 1'b0;
        while (m_tvalid && n < 200) begin
            step();
            n++;
        end
        check("drain_empty", 64'(m_tvalid), 64'd0);
    endtask

    task automatic exp_push(input logic [DATA_W-1:0] d, input logic last,
                            input logic eob, input logic [SPP_W-1:0] len);
        exp_q.push_back('{data: d, last: last, eob: eob, len: len, cyc: 0});
    endtask

    task automatic compare(input string tag);
        check({tag, "_count"}, 64'(beat_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < beat_q.size(); i++) begin
            check($sformatf("%s_beat%0d", tag, i),
                  {beat_q[i].data, beat_q[i].last, beat_q[i].eob, beat_q[i].len},
                  {exp_q[i].data, exp_q[i].last, exp_q[i].eob, exp_q[i].len});
        end
        beat_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int first_acc;
`ifdef DDC_FRAMER_STATS_EN
        logic [31:0] pkt0, eob0;
`endif
        rst_n    = 1'b0;
        clear    = 1'b0;
        cfg_spp  = 16'd4;
        s_tdata  = '0;
        s_teob   = 1'b0;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset state.
        check("rst_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_tdata",  64'(m_tdata),  64'd0);
        check("rst_tlast",  64'(m_tlast),  64'd0);
        check("rst_teob",   64'(m_teob),   64'd0);
        check("rst_tlen",   64'(m_tlen),   64'd0);
        rst_n = 1'b1;
        step();
        check("idle_tready", 64'(s_tready), 64'd1);

        // SPP boundary: spp=4, 12 samples, full throughput.
        cfg_spp = 16'd4;
        for (int i = 0; i < 12; i++) begin
            send(DATA_W'(i), 1'b0);
            if (i == 0) first_acc = cyc;
        end
        drain();
        for (int i = 0; i < 12; i++) begin
            exp_push(DATA_W'(i), (i % 4) == 3, 1'b0, ((i % 4) == 3) ? 16'd4 : 16'd0);
        end
        for (int i = 0; i < beat_q.size(); i++) begin
            check($sformatf("spp4_cycle%0d", i), 64'(beat_q[i].cyc), 64'(first_acc + i));
        end
        compare("spp4");

        // Partial packet on EOB; cfg_spp changes mid-packet are ignored.
        cfg_spp = 16'd256;
        for (int i = 0; i < 260; i++) begin
            if (i == 10)  cfg_spp = 16'd7;
            if (i == 200) cfg_spp = 16'd256;
            send(32'h1000 + DATA_W'(i), i == 259);
        end
        drain();
        for (int i = 0; i < 260; i++) begin
            if (i == 255)      exp_push(32'h1000 + DATA_W'(i), 1'b1, 1'b0, 16'd256);
            else if (i == 259) exp_push(32'h1000 + DATA_W'(i), 1'b1, 1'b1, 16'd4);
            else               exp_push(32'h1000 + DATA_W'(i), 1'b0, 1'b0, 16'd0);
        end
        compare("eob_partial");

        // Corner values.
        cfg_spp = 16'd0;
        for (int i = 0; i < 3; i++) send(32'h10 + DATA_W'(i), 1'b0);
        cfg_spp = 16'd1;
        for (int i = 0; i < 3; i++) send(32'h20 + DATA_W'(i), 1'b0);
        cfg_spp = 16'd8;
        for (int i = 0; i < 8; i++) send(32'h30 + DATA_W'(i), i == 7);
        cfg_spp = 16'd4;
        send(32'h40, 1'b1);
        for (int i = 1; i < 5; i++) send(32'h40 + DATA_W'(i), 1'b0);
        drain();
        for (int i = 0; i < 3; i++) exp_push(32'h10 + DATA_W'(i), 1'b1, 1'b0, 16'd1);
        for (int i = 0; i < 3; i++) exp_push(32'h20 + DATA_W'(i), 1'b1, 1'b0, 16'd1);
        for (int i = 0; i < 8; i++) exp_push(32'h30 + DATA_W'(i), i == 7, i == 7, (i == 7) ? 16'd8 : 16'd0);
        exp_push(32'h40, 1'b1, 1'b1, 16'd1);
        for (int i = 1; i < 5; i++) exp_push(32'h40 + DATA_W'(i), i == 4, 1'b0, (i == 4) ? 16'd4 : 16'd0);
        compare("corners");

        // Backpressure: spp=5 with random stalls, same sequence as no-stall.
        cfg_spp  = 16'd5;
        stall_en = 1'b1;
        for (int i = 0; i < 15; i++) send(32'h500 + DATA_W'(i), 1'b0);
        drain();
        stall_en = 1'b0;
        m_tready = 1'b1;
        step();
        for (int i = 0; i < 15; i++) begin
            exp_push(32'h500 + DATA_W'(i), (i % 5) == 4, 1'b0, ((i % 5) == 4) ? 16'd5 : 16'd0);
        end
        compare("stall");

        // Clear mid-packet: third sample dropped from the output register.
        cfg_spp = 16'd8;
        for (int i = 0; i < 3; i++) send(32'h600 + DATA_W'(i), 1'b0);
        clear    = 1'b1;
        s_tdata  = 32'hDEAD;
        s_tvalid = 1'b1;
        #1;
        check("clear_tready", 64'(s_tready), 64'd0);
        @(posedge clk);
        #1;
        clear    = 1'b0;
        s_tvalid = 1'b0;
        check("clear_tvalid", 64'(m_tvalid), 64'd0);
        for (int i = 0; i < 8; i++) send(32'h700 + DATA_W'(i), 1'b0);
        drain();
        exp_push(32'h600, 1'b0, 1'b0, 16'd0);
        exp_push(32'h601, 1'b0, 1'b0, 16'd0);
        for (int i = 0; i < 8; i++) exp_push(32'h700 + DATA_W'(i), i == 7, 1'b0, (i == 7) ? 16'd8 : 16'd0);
        compare("clear");

        // Asynchronous reset mid-packet with a stalled beat held.
        for (int i = 0; i < 3; i++) send(32'h800 + DATA_W'(i), 1'b0);
        m_tready = 1'b0;
        s_tvalid = 1'b0;
        #2;
        check("pre_rst_tdata", 64'(m_tdata), 64'h802);
        rst_n = 1'b0;
        #1;
        check("arst_tvalid", 64'(m_tvalid), 64'd0);
        check("arst_tdata",  64'(m_tdata),  64'd0);
        check("arst_tlast",  64'(m_tlast),  64'd0);
        check("arst_tlen",   64'(m_tlen),   64'd0);
        step();
        rst_n    = 1'b1;
        m_tready = 1'b1;
        step();
        for (int i = 0; i < 8; i++) send(32'h900 + DATA_W'(i), 1'b0);
        drain();
        exp_push(32'h800, 1'b0, 1'b0, 16'd0);
        exp_push(32'h801, 1'b0, 1'b0, 16'd0);
        for (int i = 0; i < 8; i++) exp_push(32'h900 + DATA_W'(i), i == 7, 1'b0, (i == 7) ? 16'd8 : 16'd0);
        compare("arst");

`ifdef DDC_FRAMER_STATS_EN
        // Statistics: 5 packets of 2, EOB on packets 1 and 3.
        pkt0    = stat_pkt_cnt;
        eob0    = stat_eob_cnt;
        cfg_spp = 16'd2;
        for (int i = 0; i < 10; i++) send(32'hA00 + DATA_W'(i), i == 1 || i == 5);
        drain();
        step();
        check("stat_pkt", 64'(stat_pkt_cnt - pkt0), 64'd5);
        check("stat_eob", 64'(stat_eob_cnt - eob0), 64'd2);
        clear = 1'b1;
        step();
        clear = 1'b0;
        step();
        check("stat_pkt_clear", 64'(stat_pkt_cnt - pkt0), 64'd5);
        check("stat_eob_clear", 64'(stat_eob_cnt - eob0), 64'd2);
        for (int i = 0; i < 10; i++) begin
            exp_push(32'hA00 + DATA_W'(i), (i % 2) == 1, i == 1 || i == 5, ((i % 2) == 1) ? 16'd2 : 16'd0);
        end
        compare("stats");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_ddc_out_framer

// File: doc/ddc_out_framer.md
# ddc_out_framer

Output framing stage that sits directly downstream of the DDC datapath (after the CIC/half-band decimation and IQ scaling). It takes the decimated sc16 sample stream, cuts it into packets of a programmable samples-per-packet (SPP), and closes a short packet early when the DDC marks end-of-burst. It emits tlast, an EOB flag and the packet sample count, which the CHDR packetizer downstream uses to build headers.

## Interface
- `SPP_W`, default 16: width of the SPP register and sample counter.
- `DATA_W`, default 32: sample width (sc16: I in [31:16], Q in [15:0]).
- `ddc_clk`  in  1  block clock; every register is clocked on its rising edge.
- `ddc_rst_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous flush: abandons the open packet and empties the output register.
- `cfg_spp`  in  SPP_W  samples per packet; sampled only when a packet opens.
- `s_axis_tdata`  in  DATA_W  decimated sample.
- `s_axis_teob`  in  1  marks the last sample of a burst.
- `s_axis_tvalid`  in  1  input sample is valid.
- `s_axis_tready`  out  1  block accepts the input sample.
- `m_axis_tdata`  out  DATA_W  framed sample.
- `m_axis_tlast`  out  1  last sample of the packet.
- `m_axis_teob`  out  1  packet ends a burst; meaningful only when tlast=1, 0 otherwise.
- `m_axis_tlen`  out  SPP_W  number of samples in the packet; meaningful only when tlast=1, 0 otherwise.
- `m_axis_tvalid`  out  1  output sample is valid.
- `m_axis_tready`  in  1  downstream accepts the output sample.

## Operation
- States:
  - ST_IDLE: no packet is open.
  - ST_PKT: a packet is open.
- ST_IDLE → ST_PKT on the first accepted sample.
  - `spp_q` latches `cfg_spp`; if `cfg_spp` is 0 it latches 1.
  - `cnt` is set to 1.
- In ST_PKT, each accepted sample increments `cnt`.
- A sample is the packet end when `cnt+1 == spp_q` (counting the sample itself) or when `s_axis_teob` is 1. The state then returns to ST_IDLE.
- A single-sample packet (spp_q=1, or teob on the first sample) closes in ST_IDLE without entering ST_PKT.
- On a packet-end beat:
  - tlast=1.
  - teob = s_axis_teob.
  - tlen = number of samples in the packet.
- If a burst ends exactly on the SPP boundary, the packet has tlast=1 and teob=1 with tlen=spp_q.
- Changing `cfg_spp` in the middle of a packet has no effect until the next packet opens.
- `clear`:
  - forces ST_IDLE, `cnt`=0 and m_axis_tvalid=0;
  - the sample held in the output register is discarded;
  - an input sample presented in the same cycle is not accepted (s_axis_tready=0 while clear=1).
- Sample data passes through unmodified, with no arithmetic. `cnt` is SPP_W bits wide and cannot wrap, because it resets at the end of every packet.

## Timing
- One output register stage; latency from input acceptance to m_axis_tvalid is 1 cycle.
- `s_axis_tready = !clear && (!m_axis_tvalid || m_axis_tready)`. This allows full throughput of 1 sample/cycle under continuous ready.
- Once m_axis_tvalid is asserted, the output holds tdata/tlast/teob/tlen stable until m_axis_tready is seen. Backpressure propagates to the input in the same cycle.
- Reset values:
  - outputs: m_axis_tvalid=0, tlast=0, teob=0, tlen=0, tdata=0;
  - internal: state=ST_IDLE, cnt=0, spp_q=1.
- Reset or clear in the middle of a packet: the next accepted sample starts a fresh packet with cnt=1, and no tlast is emitted for the abandoned packet.
- If clear and a pending output handshake occur in the same cycle, clear wins; the beat is dropped.

## Configuration
- `DDC_FRAMER_STATS_EN`: when defined, the block adds these outputs:
  - `stat_pkt_cnt` (32b): packets completed, counted on the output tlast handshake;
  - `stat_eob_cnt` (32b): EOB packets, counted on the output tlast && teob handshake.
- Both counters wrap at 2^32, reset on ddc_rst_n, and are not affected by `clear`.
- Without the macro these ports and counters do not exist, and the block contains no extra logic.

## Structure
- Shared package `ddc_pkg`:
  - state enum `framer_state_t` {ST_IDLE, ST_PKT};
  - constant `DDC_SAMPLE_W` = 32.
- Sub-module `ddc_out_reg`: a single-entry output register carrying {tdata, tlast, teob, tlen} with a valid/ready handshake and a clear input. It holds the only data storage.
- The framer FSM and counter live in the top module.

## Test plan
- **SPP boundary:** spp=4, 12 samples 0..11 without teob, m_axis_tready=1 → 3 packets with tlast on samples 3, 7, 11, tlen=4, teob=0, one sample per cycle after 1-cycle latency.
- **Partial packet on EOB:** spp=256, 260 samples with teob on the last → packet 1 has 256 samples, teob=0; packet 2 has tlen=4, teob=1.
- **Corner values:** spp=0 and spp=1, 3 samples → 3 single-sample packets, each tlen=1. Burst ending exactly at spp=8 (teob on sample 7) → one packet with tlen=8, teob=1.
- **Backpressure:** random m_axis_tready at 25% stall and spp=5 → output sequence identical to the no-stall case, and data is stable while valid && !ready.
- **Clear and reset mid-packet:**
  - spp=8: send 3 samples, pulse clear, send 8 samples → exactly one packet of samples after clear, tlen=8.
  - Repeat with ddc_rst_n asserted mid-packet → all outputs go to 0 immediately (asynchronous reset).
- **Stats (DDC_FRAMER_STATS_EN defined):** 5 packets, 2 of them with teob → stat_pkt_cnt=5, stat_eob_cnt=2. Counters remain unchanged after clear.
